// File: rtl/z80_mmu_waitgen.sv
// z80_mmu_waitgen: Z80 memory-management and wait-state unit.
// The logical address space is split into 2**PAGE_BITS windows. Each window is
// mapped through an I/O-writable block register onto a wide physical address.
// ROM/RAM chip selects are decoded from the physical block number, and memory
// cycles are stretched by a per-region count of WAIT states.
// Optional build macro: Z80_MMU_READBACK_EN makes the page registers readable
// through IN; without it the registers are write-only and o_data/o_data_en stay 0.
//
// state  | meaning
// IDLE   | no memory cycle in progress, WAIT released
// COUNT  | WAIT held low, down-counting the remaining wait states
// HOLD   | wait states done; parked until MREQ goes high again
module z80_mmu_waitgen #(
  parameter int          PAGE_BITS    = 2,
  parameter int          BLOCK_BITS   = 8,
  parameter int          LOGICAL_BITS = 16,
  parameter logic [7:0]  IO_BASE      = 8'h78,
  parameter int          ROM_BLOCKS   = 4,
  parameter int          WAIT_BITS    = 3,
  parameter int          ROM_WAIT     = 2,
  parameter int          RAM_WAIT     = 0,
  localparam int         OFFSET_BITS  = LOGICAL_BITS - PAGE_BITS,
  localparam int         NPAGES       = 2 ** PAGE_BITS
) (
  input  logic                              i_clk,
  input  logic                              i_reset_n,
  input  logic [LOGICAL_BITS-1:0]           i_addr,
  input  logic                              i_mreq_n,
  input  logic                              i_iorq_n,
  input  logic                              i_m1_n,
  input  logic                              i_rfsh_n,
  input  logic                              i_rd_n,
  input  logic                              i_wr_n,
  input  logic [7:0]                        i_data,
  output logic [7:0]                        o_data,
  output logic                              o_data_en,
  output logic [OFFSET_BITS+BLOCK_BITS-1:0] o_paddr,
  output logic                              o_rom_cs_n,
  output logic                              o_ram_cs_n,
  output logic                              o_wait_n
);

  // Widened limits so the compares below are unsigned and width-matched.
  localparam logic [8:0]            NPAGES_LIM = 9'(NPAGES);
  localparam logic [BLOCK_BITS:0]   ROM_LIM    = (BLOCK_BITS+1)'(ROM_BLOCKS);
  localparam logic [WAIT_BITS-1:0]  ROM_N      = WAIT_BITS'(ROM_WAIT);
  localparam logic [WAIT_BITS-1:0]  RAM_N      = WAIT_BITS'(RAM_WAIT);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  logic [BLOCK_BITS-1:0] page_q [NPAGES];
  logic                  io_done_q, io_done_d;
  state_t                state_q, state_d;
  logic [WAIT_BITS-1:0]  cnt_q, cnt_d;
  logic                  wait_n_q, wait_n_d;

  logic [PAGE_BITS-1:0]  sel;
  logic [BLOCK_BITS-1:0] blk;
  logic                  mem;
  logic                  is_rom;
  logic [7:0]            io_off;
  logic [PAGE_BITS-1:0]  io_k;
  logic                  io_hit;
  logic                  wr_hit;
  logic [WAIT_BITS-1:0]  n_wait;

  // Address translation, chip-select and I/O port decode.
  always_comb begin
    sel        = i_addr[LOGICAL_BITS-1 -: PAGE_BITS];
    blk        = page_q[sel];
    o_paddr    = {blk, i_addr[OFFSET_BITS-1:0]};
    mem        = ~i_mreq_n & i_rfsh_n;
    is_rom     = {1'b0, blk} < ROM_LIM;
    o_rom_cs_n = ~(i_reset_n & mem & is_rom);
    o_ram_cs_n = ~(i_reset_n & mem & ~is_rom);
    // 8-bit wrap makes ports below IO_BASE land far above NPAGES and miss.
    io_off     = i_addr[7:0] - IO_BASE;
    io_k       = io_off[PAGE_BITS-1:0];
    io_hit     = ~i_iorq_n & i_m1_n & ({1'b0, io_off} < NPAGES_LIM);
    wr_hit     = io_hit & ~i_wr_n & ~io_done_q;
    io_done_d  = io_done_q;
    if (wr_hit)
      io_done_d = 1'b1;
    else if (i_iorq_n)
      io_done_d = 1'b0;
    n_wait     = is_rom ? ROM_N : RAM_N;
  end

  // Page registers and the once-per-OUT write guard.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int k = 0; k < NPAGES; k++)
        page_q[k] <= BLOCK_BITS'(k);
      io_done_q <= 1'b0;
    end else begin
      if (wr_hit)
        page_q[io_k] <= BLOCK_BITS'(i_data);
      io_done_q <= io_done_d;
    end
  end

  // Wait FSM next-state and registered WAIT value.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wait_n_d = wait_n_q;
    unique case (state_q)
      ST_IDLE: begin
        if (mem) begin
          if (n_wait != '0) begin
            cnt_d    = n_wait - 1'b1;
            wait_n_d = 1'b0;
            state_d  = ST_COUNT;
          end else begin
            wait_n_d = 1'b1;
            state_d  = ST_HOLD;
          end
        end
      end
      ST_COUNT: begin
        if (i_mreq_n) begin
          wait_n_d = 1'b1;
          state_d  = ST_IDLE;
        end else if (cnt_q == '0) begin
          wait_n_d = 1'b1;
          state_d  = ST_HOLD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_HOLD: begin
        wait_n_d = 1'b1;
        if (i_mreq_n)
          state_d = ST_IDLE;
      end
      default: begin
        wait_n_d = 1'b1;
        state_d  = ST_IDLE;
      end
    endcase
  end

  // Wait FSM state register.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      wait_n_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wait_n_q <= wait_n_d;
    end
  end

  assign o_wait_n = wait_n_q;

`ifdef Z80_MMU_READBACK_EN
  // Register read-back onto the CPU bus during IN from a page port.
  always_comb begin
    o_data_en = i_reset_n & io_hit & ~i_rd_n;
    o_data    = o_data_en ? 8'(page_q[io_k]) : 8'h00;
  end
`else
  logic unused_rd;
  assign unused_rd = i_rd_n;
  assign o_data_en = 1'b0;
  assign o_data    = 8'h00;
`endif

endmodule

// File: tb/tb_z80_mmu_waitgen.sv
// tb_z80_mmu_waitgen: directed bus cycles followed by random ones, checked
// against a bus-cycle-level model of the page map and wait counts.
module tb_z80_mmu_waitgen;

  localparam int ROM_BLOCKS = 4;
  localparam int ROM_WAIT   = 2;
  localparam int RAM_WAIT   = 0;
  localparam int OFF_BITS   = 14;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] addr;
  logic        mreq_n, iorq_n, m1_n, rfsh_n, rd_n, wr_n;
  logic [7:0]  din;
  logic [7:0]  dout;
  logic        dout_en;
  logic [21:0] paddr;
  logic        rom_cs_n, ram_cs_n, wait_n;

  int errors = 0;
  int checks = 0;
  int model_page [4];

  z80_mmu_waitgen #(
    .PAGE_BITS(2), .BLOCK_BITS(8), .LOGICAL_BITS(16), .IO_BASE(8'h78),
    .ROM_BLOCKS(ROM_BLOCKS), .WAIT_BITS(3), .ROM_WAIT(ROM_WAIT), .RAM_WAIT(RAM_WAIT)
  ) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_addr(addr), .i_mreq_n(mreq_n),
    .i_iorq_n(iorq_n), .i_m1_n(m1_n), .i_rfsh_n(rfsh_n), .i_rd_n(rd_n),
    .i_wr_n(wr_n), .i_data(din), .o_data(dout), .o_data_en(dout_en),
    .o_paddr(paddr), .o_rom_cs_n(rom_cs_n), .o_ram_cs_n(ram_cs_n), .o_wait_n(wait_n)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int port_index(input int port);
    return (port - 8'h78) & 8'hFF;
  endfunction

  task automatic bus_idle();
    mreq_n = 1'b1; iorq_n = 1'b1; m1_n = 1'b1; rfsh_n = 1'b1;
    rd_n = 1'b1; wr_n = 1'b1;
  endtask

  task automatic model_reset();
    for (int k = 0; k < 4; k++) model_page[k] = k;
  endtask

  task automatic mem_cycle(input logic [15:0] a, input bit is_wr);
    int blk, nw;
    bit rom;
    @(negedge clk);
    addr = a; mreq_n = 1'b0; din = 8'($urandom);
    if (is_wr) wr_n = 1'b0; else rd_n = 1'b0;
    #1;
    blk = model_page[a / (1 << OFF_BITS)];
    rom = blk < ROM_BLOCKS;
    check("paddr", 32'(paddr), 32'(blk * (1 << OFF_BITS) + (a % (1 << OFF_BITS))));
    check("rom_cs_n", 32'(rom_cs_n), 32'(!rom));
    check("ram_cs_n", 32'(ram_cs_n), 32'(rom));
    nw = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (!wait_n) nw++;
    end
    check("wait_len", 32'(nw), 32'(rom ? ROM_WAIT : RAM_WAIT));
    bus_idle();
    @(negedge clk);
    check("wait_idle", 32'(wait_n), 32'd1);
  endtask

  task automatic io_write(input logic [7:0] port, input logic [7:0] d);
    int k;
    @(negedge clk);
    addr = {8'($urandom), port}; iorq_n = 1'b0; wr_n = 1'b0; din = d;
    @(negedge clk);
    din = ~d;
    check("io_no_wait", 32'(wait_n), 32'd1);
    @(negedge clk);
    @(negedge clk);
    bus_idle();
    k = port_index(port);
    if (k < 4) model_page[k] = d;
    @(negedge clk);
  endtask

  task automatic io_read(input logic [7:0] port);
    int k;
    @(negedge clk);
    addr = {8'($urandom), port}; iorq_n = 1'b0; rd_n = 1'b0;
    #1;
    k = port_index(port);
`ifdef Z80_MMU_READBACK_EN
    check("rb_en", 32'(dout_en), 32'(k < 4));
    check("rb_data", 32'(dout), (k < 4) ? 32'(model_page[k]) : 32'd0);
`else
    check("rb_en", 32'(dout_en), 32'd0);
    check("rb_data", 32'(dout), 32'd0);
`endif
    @(negedge clk);
    bus_idle();
    @(negedge clk);
  endtask

  task automatic int_ack(input logic [7:0] port, input logic [7:0] d);
    @(negedge clk);
    addr = {8'($urandom), port}; iorq_n = 1'b0; m1_n = 1'b0; wr_n = 1'b0; din = d;
    @(negedge clk);
    @(negedge clk);
    bus_idle();
    @(negedge clk);
  endtask

  task automatic refresh(input logic [15:0] a);
    @(negedge clk);
    addr = a; mreq_n = 1'b0; rfsh_n = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      check("rfsh_rom_cs", 32'(rom_cs_n), 32'd1);
      check("rfsh_ram_cs", 32'(ram_cs_n), 32'd1);
      check("rfsh_wait", 32'(wait_n), 32'd1);
      @(negedge clk);
    end
    bus_idle();
    @(negedge clk);
  endtask

  task automatic check_map();
    for (int k = 0; k < 4; k++)
      mem_cycle(16'((k << OFF_BITS) | $urandom_range(0, 16'h3FFF)), 1'b0);
  endtask

  initial begin
    bus_idle();
    addr = 16'h0000; din = 8'h00;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    mreq_n = 1'b0;
    #1;
    check("rst_wait", 32'(wait_n), 32'd1);
    check("rst_rom_cs", 32'(rom_cs_n), 32'd1);
    check("rst_ram_cs", 32'(ram_cs_n), 32'd1);
    check("rst_data_en", 32'(dout_en), 32'd0);
    check("rst_data", 32'(dout), 32'd0);
    bus_idle();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    mem_cycle(16'h0000, 1'b0);
    mem_cycle(16'h4000, 1'b0);

    io_write(8'h7A, 8'h23);
    mem_cycle(16'h8123, 1'b0);

    io_write(8'h7C, 8'h55);
    int_ack(8'h78, 8'h99);
    check_map();

    refresh(16'h0000);

    // Reset pulse while the ROM wait counter is mid-count.
    @(negedge clk);
    addr = 16'h0100; mreq_n = 1'b0; rd_n = 1'b0;
    @(negedge clk);
    check("pre_rst_wait", 32'(wait_n), 32'd0);
    rst_n = 1'b0;
    #1;
    check("rst_mid_wait", 32'(wait_n), 32'd1);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    bus_idle();
    @(negedge clk);
    check_map();

    io_write(8'h7B, 8'hA5);
    io_read(8'h7B);
    io_read(8'h77);

    for (int it = 0; it < 250; it++) begin
      logic [7:0] port;
      port = ($urandom_range(0, 1) == 0) ? 8'(8'h78 + $urandom_range(0, 3)) : 8'($urandom);
      case ($urandom_range(0, 5))
        0, 1:    mem_cycle(16'($urandom), 1'($urandom));
        2:       io_write(port, 8'($urandom_range(0, 7)));
        3:       io_read(port);
        4:       int_ack(port, 8'($urandom));
        default: refresh(16'($urandom));
      endcase
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
